// File: rtl/pkt_rd_engine_pkg.sv
// Shared types for the packet read engine.
//   DEF_AW/DEF_LW/DEF_DW : default address, length and data widths
//   descT                : arbitrated descriptor {startAddr, len}
//   beatT                : output beat {sop, eop, data}
//   rdStateT             : read FSM state
package pkt_rd_engine_pkg;

  localparam int unsigned DEF_AW = 12;
  localparam int unsigned DEF_LW = 6;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic {
    IDLE,
    READ
  } rdStateT;

  typedef struct packed {
    logic [DEF_AW-1:0] startAddr;
    logic [DEF_LW-1:0] len;
  } descT;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DEF_DW-1:0] data;
  } beatT;

endpackage

// File: rtl/pkt_rd_beat_fifo.sv
// Two-entry beat FIFO with fall-through.
//   iClk, iRst_n : clock, asynchronous active-low reset
//   iPush/iPushData : write a beat (arrives the cycle after the SRAM read)
//   iPop         : consume the head (ignored when nothing is valid)
//   oVld/oHead   : head valid and head beat; an incoming beat is presented
//                  directly when the FIFO holds nothing
//   oCount       : number of stored entries (0..2), used for read credit
module pkt_rd_beat_fifo #(
  parameter int unsigned W = 34
) (
  input  logic         iClk,
  input  logic         iRst_n,
  input  logic         iPush,
  input  logic [W-1:0] iPushData,
  input  logic         iPop,
  output logic         oVld,
  output logic [W-1:0] oHead,
  output logic [1:0]   oCount
);

  logic [W-1:0] mem [2];
  logic         wrPtr;
  logic         rdPtr;
  logic         empty;
  logic         store;
  logic         popMem;

  assign empty = (oCount == 2'd0);

  // An incoming beat consumed in the same cycle it arrives on an empty
  // FIFO bypasses storage entirely.
  assign store  = iPush && !(empty && iPop);
  assign popMem = iPop && !empty;

  always_comb begin
    oVld  = !empty || iPush;
    oHead = empty ? iPushData : mem[rdPtr];
  end

  always_ff @(posedge iClk) begin
    if (store) begin
      mem[wrPtr] <= iPushData;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      oCount <= 2'd0;
    end else begin
      if (store) begin
        wrPtr <= ~wrPtr;
      end
      if (popMem) begin
        rdPtr <= ~rdPtr;
      end
      oCount <= oCount + {1'b0, store} - {1'b0, popMem};
    end
  end

endmodule

// File: rtl/pkt_rd_engine.sv
// Packet read engine: takes arbitrated descriptors, reads len words from the
// packet-buffer SRAM starting at startAddr (address wraps modulo 2^AW) and
// streams them out as beats tagged with sop/eop.
//   iClk, iRst_n          : clock, asynchronous active-low reset
//   iDcpDescVld/Pld/oDcpDescRdy : descriptor slave {startAddr, len}
//   oRdEn, oRdAddr, iRdData     : SRAM read port, data one cycle after oRdEn
//   oDcpDataVld/Pld/iDcpDataRdy : beat master {sop, eop, data}
//   oBusy                 : FSM active, read in flight or beats buffered
module pkt_rd_engine
  import pkt_rd_engine_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned LW = DEF_LW,
  parameter int unsigned DW = DEF_DW
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iDcpDescVld,
  input  logic [AW+LW-1:0] iDcpDescPld,
  output logic          oDcpDescRdy,
  output logic          oRdEn,
  output logic [AW-1:0] oRdAddr,
  input  logic [DW-1:0] iRdData,
  output logic          oDcpDataVld,
  output logic [DW+1:0] oDcpDataPld,
  input  logic          iDcpDataRdy,
  output logic          oBusy
);

  rdStateT       state;
  rdStateT       stateNext;
  logic [AW-1:0] startAddr;
  logic [LW-1:0] len;
  logic [LW-1:0] beatCnt;
  logic          inFlight;
  logic          inFlightSop;
  logic          inFlightEop;
  logic [1:0]    fifoCount;
  logic [AW-1:0] descAddr;
  logic [LW-1:0] descLen;
  logic          accept;
  logic          lastBeat;
  logic          pop;
  logic [2:0]    occupancy;
  logic          credit;

  assign descAddr = iDcpDescPld[AW+LW-1:LW];
  assign descLen  = iDcpDescPld[LW-1:0];
  assign accept   = iDcpDescVld && oDcpDescRdy;
  assign lastBeat = (beatCnt == len - LW'(1));
  assign pop      = oDcpDataVld && iDcpDataRdy;
  assign oRdAddr  = startAddr + AW'(beatCnt);

  // At most two beats may be stored or outstanding; a pop this cycle frees
  // a slot, which keeps 1 beat/cycle when the consumer is always ready.
  assign occupancy = {1'b0, fifoCount} + {2'b00, inFlight};
  assign credit    = (occupancy < 3'd2) || pop;

  always_comb begin
    stateNext   = state;
    oDcpDescRdy = 1'b0;
    oRdEn       = 1'b0;
    case (state)
      IDLE: begin
        oDcpDescRdy = 1'b1;
        if (accept && (descLen != '0)) begin
          stateNext = READ;
        end
      end
      READ: begin
        if (credit) begin
          oRdEn = 1'b1;
          if (lastBeat) begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      startAddr   <= '0;
      len         <= '0;
      beatCnt     <= '0;
      inFlight    <= 1'b0;
      inFlightSop <= 1'b0;
      inFlightEop <= 1'b0;
    end else begin
      if (accept && (descLen != '0)) begin
        startAddr <= descAddr;
        len       <= descLen;
        beatCnt   <= '0;
      end else if (oRdEn) begin
        beatCnt <= beatCnt + LW'(1);
      end
      // Reset clears inFlight, so data from a read issued before reset is
      // never pushed.
      inFlight    <= oRdEn;
      inFlightSop <= oRdEn && (beatCnt == '0);
      inFlightEop <= oRdEn && lastBeat;
    end
  end

  pkt_rd_beat_fifo #(
    .W(DW + 2)
  ) uBeatFifo (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iPush     (inFlight),
    .iPushData ({inFlightSop, inFlightEop, iRdData}),
    .iPop      (pop),
    .oVld      (oDcpDataVld),
    .oHead     (oDcpDataPld),
    .oCount    (fifoCount)
  );

  assign oBusy = (state != IDLE) || inFlight || (fifoCount != 2'd0);

endmodule

// File: tb/tb_pkt_rd_engine.sv
module tb_pkt_rd_engine;
  import pkt_rd_engine_pkg::*;

  localparam int unsigned AW = DEF_AW;
  localparam int unsigned LW = DEF_LW;
  localparam int unsigned DW = DEF_DW;

  logic          clk = 1'b0;
  logic          rstN;
  logic          descVld;
  logic [AW+LW-1:0] descPld;
  logic          descRdy;
  logic          rdEn;
  logic [AW-1:0] rdAddr;
  logic [DW-1:0] rdData;
  logic          dataVld;
  logic [DW+1:0] dataPld;
  logic          dataRdy;
  logic          busy;

  always #5 clk = ~clk;

  pkt_rd_engine #(
    .AW(AW),
    .LW(LW),
    .DW(DW)
  ) dut (
    .iClk        (clk),
    .iRst_n      (rstN),
    .iDcpDescVld (descVld),
    .iDcpDescPld (descPld),
    .oDcpDescRdy (descRdy),
    .oRdEn       (rdEn),
    .oRdAddr     (rdAddr),
    .iRdData     (rdData),
    .oDcpDataVld (dataVld),
    .oDcpDataPld (dataPld),
    .iDcpDataRdy (dataRdy),
    .oBusy       (busy)
  );

  // SRAM model: registered read, data valid the cycle after rdEn
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (rdEn) rdData <= mem[rdAddr];
  end

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  task automatic chkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted descriptor expands to its address list
  // and beat list; the DUT must consume them strictly in order.
  logic [AW-1:0] expAddrQ [$];
  beatT          expBeatQ [$];
  int unsigned   issued, popped, cyc, lastRdCyc;
  logic          prevHold;
  logic [DW+1:0] prevPld;
  int            rdyMode = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rstN) begin
      expAddrQ.delete();
      expBeatQ.delete();
      issued   = 0;
      popped   = 0;
      prevHold = 1'b0;
    end else begin
      if (rdEn) begin
        if (expAddrQ.size() == 0) chkVal("unexpected_read", 1, 0);
        else chkVal("rd_addr", rdAddr, expAddrQ.pop_front());
        issued++;
        lastRdCyc = cyc;
      end
      if (prevHold) begin
        chkVal("hold_vld", dataVld, 1);
        chkVal("hold_pld", dataPld, prevPld);
      end
      if (dataVld && dataRdy) begin
        if (expBeatQ.size() == 0) chkVal("unexpected_beat", 1, 0);
        else chkVal("beat", dataPld, expBeatQ.pop_front());
        popped++;
      end
      if (rdEn) chkVal("outstanding_le2", (issued - popped) <= 2, 1);
      prevHold = dataVld && !dataRdy;
      prevPld  = dataPld;
    end
  end

  // Consumer ready: 0 always ready, 1 pattern 1,0,0,1, 2 random
  initial begin
    int unsigned patIdx = 0;
    dataRdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdyMode)
        1:       dataRdy = ((patIdx % 4) == 0) || ((patIdx % 4) == 3);
        2:       dataRdy = 1'($urandom_range(0, 1));
        default: dataRdy = 1'b1;
      endcase
      patIdx++;
    end
  end

  task automatic sendDesc(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          output int unsigned accCyc);
    descT d;
    bit   done = 0;
    int unsigned n = l;
    accCyc = 0;
    @(posedge clk);
    #1;
    d.startAddr = a;
    d.len       = l;
    descVld     = 1'b1;
    descPld     = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (descRdy) begin
        done   = 1;
        accCyc = cyc;
        for (int unsigned k = 0; k < n; k++) begin
          logic [AW-1:0] ad;
          beatT b;
          ad     = a + AW'(k);
          b.sop  = (k == 0);
          b.eop  = (k == n - 1);
          b.data = mem[ad];
          expAddrQ.push_back(ad);
          expBeatQ.push_back(b);
        end
      end
    end
    if (!done) chkVal("desc_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    descVld = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    bit idle = 0;
    for (int i = 0; i < 600 && !idle; i++) begin
      @(negedge clk);
      if (!busy && expBeatQ.size() == 0 && expAddrQ.size() == 0) idle = 1;
    end
    chkVal({tag, "_busy"}, busy, 0);
    chkVal({tag, "_beats_left"}, expBeatQ.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc1, acc2;
    rstN    = 1'b0;
    descVld = 1'b0;
    descPld = '0;
    rdData  = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

    #12;
    chkVal("rst_rden", rdEn, 0);
    chkVal("rst_addr", rdAddr, 0);
    chkVal("rst_vld", dataVld, 0);
    chkVal("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    chkVal("post_rst_rdy", descRdy, 1);

    // Basic packet and latency
    sendDesc(12'h010, 6'd4, acc1);
    @(negedge clk);
    chkVal("lat_rden_t1", rdEn, 1);
    @(negedge clk);
    chkVal("lat_vld_t2", dataVld, 1);
    waitIdle("basic");

    // Address wrap
    sendDesc(12'hFFE, 6'd4, acc1);
    waitIdle("wrap");

    // Single-beat packet
    sendDesc(12'h055, 6'd1, acc1);
    waitIdle("len1");

    // Zero-length descriptor is swallowed
    sendDesc(12'h123, 6'd0, acc1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chkVal("len0_rdy", descRdy, 1);
      chkVal("len0_rden", rdEn, 0);
      chkVal("len0_vld", dataVld, 0);
    end

    // Backpressure pattern 1,0,0,1
    rdyMode = 1;
    sendDesc(12'h080, 6'd8, acc1);
    waitIdle("stall");
    rdyMode = 0;

    // Back-to-back descriptors
    sendDesc(12'h100, 6'd3, acc1);
    sendDesc(12'h200, 6'd2, acc2);
    chkVal("b2b_accept_gap", acc2 - lastRdCyc, 1);
    waitIdle("b2b");

    // Random descriptors under random backpressure
    rdyMode = 2;
    for (int i = 0; i < 40; i++) begin
      sendDesc(AW'($urandom), LW'($urandom_range(0, 9)), acc1);
    end
    waitIdle("random");
    rdyMode = 0;

    // Reset in the middle of a packet
    sendDesc(12'h300, 6'd6, acc1);
    repeat (4) @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    chkVal("midrst_rden", rdEn, 0);
    chkVal("midrst_addr", rdAddr, 0);
    chkVal("midrst_vld", dataVld, 0);
    chkVal("midrst_busy", busy, 0);
    chkVal("midrst_rdy", descRdy, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rstN = 1'b1;
    sendDesc(12'h040, 6'd2, acc1);
    waitIdle("after_rst");
    chkVal("after_rst_beat_count", popped, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
